// File: rtl/second_timer.sv
// Seconds countdown driven by the divider's one-second toggle, with stall watchdog.
// Tick visible 3 clk after the toggle edge, countdown update 1 clk later; no backpressure.
module second_timer #(
    parameter int          SEC_W       = 4,
    parameter logic [26:0] STALL_LIMIT = 27'd110_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_toggle,
    input  logic             start,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             pause,
    input  logic             abort,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [SEC_W-1:0] remaining,
    output logic             stall
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_EXPIRE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_tick;
    logic [SEC_W-1:0] r_remaining;
    logic [26:0]      r_wd_cnt;
    logic [26:0]      w_wd_inc;
    logic             r_stall;
    logic             w_start_ok;
    logic             w_dec;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_dec      = (r_state == S_RUN) && !abort && r_tick && !pause
                        && (r_remaining != '0);
    assign w_wd_inc   = (r_wd_cnt >= STALL_LIMIT) ? STALL_LIMIT : r_wd_cnt + 27'd1;

    // Every transition of the synchronised toggle, either direction, is one second.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_s1   <= tick_toggle;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_tick <= r_s2 ^ r_s3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (load_sec == '0) ? S_EXPIRE : S_ARMED;
                end
            end
            S_ARMED:  w_next = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_dec && (r_remaining == SEC_W'(1))) begin
                    w_next = S_EXPIRE;
                end
            end
            S_EXPIRE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_ARMED) || (r_state == S_RUN);
        done = (r_state == S_EXPIRE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining <= '0;
        end else if (w_start_ok) begin
            r_remaining <= load_sec;
        end else if (w_dec) begin
            r_remaining <= r_remaining - SEC_W'(1);
        end
    end

    // Watchdog only counts while the countdown is actually waiting on a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else if (w_start_ok) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else if (r_tick) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (pause) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= w_wd_inc;
                if (w_wd_inc == STALL_LIMIT) begin
                    r_stall <= 1'b1;
                end
            end
        end
    end

    assign tick      = r_tick;
    assign remaining = r_remaining;
    assign stall     = r_stall;

endmodule

// File: tb/tb_second_timer.sv
// Directed bench for second_timer with a per-cycle behavioural reference model.
module tb_second_timer;

    localparam int LIMIT = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       tog_q;
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] load_sec;
    logic       tick;
    logic       busy;
    logic       done;
    logic [3:0] remaining;
    logic       stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit tog_en;
    int tog_cnt;

    always #5 clk = ~clk;

    second_timer #(.SEC_W(4), .STALL_LIMIT(27'd20)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_toggle(tog_q),
        .start      (start),
        .load_sec   (load_sec),
        .pause      (pause),
        .abort      (abort),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .stall      (stall)
    );

    // Reference model: ticks are scheduled two edges after the edge that sees a
    // toggle change; the countdown consumes the tick visible before each edge.
    int   m_cyc;
    int   m_due[$];
    logic m_last;
    bit   m_tick, m_busy, m_fresh, m_done, m_stall;
    int   m_rem, m_wd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_due.delete(); m_last = 1'b0; m_tick = 0;
            m_busy = 0; m_fresh = 0; m_done = 0; m_stall = 0; m_rem = 0; m_wd = 0;
        end else begin
            bit t, running, idle_pre;
            t        = m_tick;
            running  = m_busy && !m_fresh;
            idle_pre = !m_busy && !m_done;
            if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_rem = int'(load_sec); m_stall = 0; m_wd = 0;
                    if (load_sec == 4'd0) m_done = 1;
                    else begin m_busy = 1; m_fresh = 1; end
                end
            end else if (abort) begin
                m_busy = 0; m_fresh = 0;
            end else if (m_fresh) begin
                m_fresh = 0;
            end else if (t && !pause && m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 0; m_done = 1; end
            end
            if (!(idle_pre && start)) begin
                if (t) m_wd = 0;
                else if (running) begin
                    if (pause) m_wd = 0;
                    else if (m_wd < LIMIT) begin
                        m_wd = m_wd + 1;
                        if (m_wd == LIMIT) m_stall = 1;
                    end
                end
            end
            m_cyc = m_cyc + 1;
            if (tog_q !== m_last) begin
                m_due.push_back(m_cyc + 2);
                m_last = tog_q;
            end
            m_tick = 0;
            if (m_due.size() > 0 && m_due[0] == m_cyc) begin
                m_tick = 1;
                void'(m_due.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare outputs to the model, advance the toggle source, drop pulses.
    task automatic step();
        @(negedge clk);
        chk("tick",      int'(tick),      int'(m_tick));
        chk("busy",      int'(busy),      int'(m_busy));
        chk("done",      int'(done),      int'(m_done));
        chk("remaining", int'(remaining), m_rem);
        chk("stall",     int'(stall),     int'(m_stall));
        if (tog_en) begin
            tog_cnt++;
            if (tog_cnt == 10) begin
                tog_cnt = 0;
                tog_q   = ~tog_q;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        bit   found;
        int   cnt;
        logic [3:0] last;
        int   seq[$];

        reset = 1'b0; tog_q = 1'b0; tog_en = 0; tog_cnt = 0;
        start = 1'b0; abort = 1'b0; pause = 1'b0; load_sec = 4'd0;
        #12;
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rem",  int'(remaining), 0);
        chk("rst_stall", int'(stall), 0);
        step(); step();
        reset = 1'b1; tog_en = 1;
        repeat (3) step();

        // 1: countdown of 3
        load_sec = 4'd3; start = 1'b1;
        step();
        chk("t1_rem_load", int'(remaining), 3);
        chk("t1_busy", int'(busy), 1);
        last = remaining; found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (remaining != last) begin seq.push_back(int'(remaining)); last = remaining; end
            if (done) begin found = 1; break; end
        end
        chk("t1_done_seen", int'(found), 1);
        chk("t1_nsteps", seq.size(), 3);
        if (seq.size() == 3) begin
            chk("t1_seq0", seq[0], 2);
            chk("t1_seq1", seq[1], 1);
            chk("t1_seq2", seq[2], 0);
        end
        chk("t1_busy_at_done", int'(busy), 0);
        step();
        chk("t1_done_end", int'(done), 0);

        // 2: zero load
        load_sec = 4'd0; start = 1'b1;
        step();
        chk("t2_done", int'(done), 1);
        chk("t2_busy", int'(busy), 0);
        chk("t2_rem", int'(remaining), 0);
        step();
        chk("t2_done_end", int'(done), 0);
        chk("t2_busy_end", int'(busy), 0);

        // 3: pause across two toggles
        load_sec = 4'd5; start = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (remaining == 4'd4) begin found = 1; break; end
        end
        chk("t3_first_tick", int'(found), 1);
        pause = 1'b1;
        repeat (20) step();
        chk("t3_hold", int'(remaining), 4);
        pause = 1'b0;
        found = 0; cnt = 0; last = remaining;
        for (int i = 0; i < 100; i++) begin
            step();
            if (remaining != last) begin cnt++; last = remaining; end
            if (done) begin found = 1; break; end
        end
        chk("t3_done_seen", int'(found), 1);
        chk("t3_decrements", cnt, 4);
        chk("t3_rem_end", int'(remaining), 0);
        step();

        // 4: ignored restart, then abort coinciding with a tick
        load_sec = 4'd4; start = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (remaining == 4'd3) begin found = 1; break; end
        end
        chk("t4_reach3", int'(found), 1);
        load_sec = 4'd9; start = 1'b1;
        step();
        chk("t4_no_reload", int'(remaining), 3);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick && remaining == 4'd2) begin found = 1; abort = 1'b1; break; end
        end
        chk("t4_tick_at2", int'(found), 1);
        step();
        chk("t4_busy", int'(busy), 0);
        chk("t4_rem", int'(remaining), 2);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) cnt++;
        end
        chk("t4_no_done", cnt, 0);
        chk("t4_rem_hold", int'(remaining), 2);

        // 5: frozen tick source trips the watchdog
        load_sec = 4'd9; start = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (remaining == 4'd7) begin found = 1; break; end
        end
        chk("t5_reach7", int'(found), 1);
        tog_en = 0;
        cnt = 0; found = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (stall) begin found = 1; cnt = i; break; end
        end
        chk("t5_stall_seen", int'(found), 1);
        chk("t5_stall_delay", cnt, 20);
        repeat (5) step();
        chk("t5_stall_sticky", int'(stall), 1);
        chk("t5_rem_frozen", int'(remaining), 7);
        chk("t5_busy", int'(busy), 1);
        tog_en = 1; abort = 1'b1;
        step();
        load_sec = 4'd2; start = 1'b1;
        step();
        chk("t5_stall_clr", int'(stall), 0);
        chk("t5_busy_new", int'(busy), 1);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done) begin found = 1; break; end
        end
        chk("t5_done_seen", int'(found), 1);
        step();

        // 6: asynchronous reset mid-countdown
        load_sec = 4'd5; start = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (remaining == 4'd2) begin found = 1; break; end
        end
        chk("t6_reach2", int'(found), 1);
        step();
        #2;
        reset = 1'b0; tog_en = 0; tog_q = 1'b0; tog_cnt = 0;
        #1;
        chk("t6_tick", int'(tick), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_rem", int'(remaining), 0);
        chk("t6_stall", int'(stall), 0);
        step(); step();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tick) cnt++;
            if (done) cnt++;
        end
        chk("t6_no_tick", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
